// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor applying RPC rounds per clock.
// Optional AES_ZEROIZE_EN: clear state/key on output handshake, mask out_block.

module round_comb #(
    parameter int KEY_SIZE = 128
) (
    input  logic [127:0]        state,
    input  logic [KEY_SIZE-1:0] key,
    input  logic [3:0]          num,
    output logic [127:0]        next
);
    localparam int NK      = KEY_SIZE / 32;
    localparam int RND_NUM = NK + 6;
    localparam int NW      = 4 * (RND_NUM + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]),
                sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    logic [31:0]  w [NW];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] rk;

    always_comb begin
        rc = 8'h01;
        t  = '0;
        for (int i = 0; i < NK; i++) begin
            w[i] = key[KEY_SIZE-1-32*i -: 32];
        end
        for (int i = NK; i < NW; i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = subword(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        rk = '0;
        for (int j = 0; j <= RND_NUM; j++) begin
            if (num == 4'(j)) begin
                rk = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            end
        end
    end

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] mc;
    logic         is_final;

    assign is_final = (num == 4'(RND_NUM));

    always_comb begin
        for (int b = 0; b < 16; b++) begin
            sb[b] = sbox(state[127-8*b -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        mc = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (is_final) begin
                mc[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                mc[127-32*c -: 32] = {
                    xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
    end

    assign next = mc ^ rk;
endmodule

module aes_iter_core #(
    parameter int KEY_SIZE = 128,
    parameter int RPC      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    input  logic [KEY_SIZE-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block
);
    localparam int         RND_NUM = KEY_SIZE / 32 + 6;
    localparam logic [3:0] LAST    = 4'(RND_NUM);
    localparam logic [3:0] STEP    = 4'(RPC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t                fsm_q;
    logic [127:0]        state_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [3:0]          rnd_q;
    logic [127:0]        chain [RPC+1];
    logic                last_step;

    assign chain[0] = state_q;

    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        round_comb #(
            .KEY_SIZE(KEY_SIZE)
        ) u_rnd (
            .state(chain[k]),
            .key  (key_q),
            .num  (rnd_q + 4'(k)),
            .next (chain[k+1])
        );
    end

    assign last_step = (rnd_q + STEP - 4'd1 == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_block ^ in_key[KEY_SIZE-1 -: 128];
                        key_q   <= in_key;
                        rnd_q   <= 4'd1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= chain[RPC];
                    if (last_step) begin
                        rnd_q <= LAST;
                        fsm_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q <= IDLE;
                        rnd_q <= '0;
`ifdef AES_ZEROIZE_EN
                        state_q <= '0;
                        key_q   <= '0;
`endif
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
`ifdef AES_ZEROIZE_EN
    assign out_block = out_valid ? state_q : '0;
`else
    assign out_block = state_q;
`endif
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: scoreboard bench on FIPS-197 / SP800-38A vectors.
// Covers all key sizes, RPC 1/2, backpressure, mid-run reset, streaming.

module tb_aes_iter_core;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] K192   =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256   =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KB     = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_block, a_in_key, a_out_block;

    logic         w_in_valid, w_out_ready;
    logic [127:0] w_in_block;
    logic [191:0] w_key192;
    logic [255:0] w_key256;
    logic         b_in_ready, b_out_valid;
    logic         c_in_ready, c_out_valid;
    logic         d_in_ready, d_out_valid;
    logic [127:0] b_out_block, c_out_block, d_out_block;

    aes_iter_core #(.KEY_SIZE(128), .RPC(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_block(a_in_block), .in_key(a_in_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_block(a_out_block));

    aes_iter_core #(.KEY_SIZE(192), .RPC(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(b_in_ready),
        .in_block(w_in_block), .in_key(w_key192),
        .out_valid(b_out_valid), .out_ready(w_out_ready),
        .out_block(b_out_block));

    aes_iter_core #(.KEY_SIZE(256), .RPC(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(c_in_ready),
        .in_block(w_in_block), .in_key(w_key256),
        .out_valid(c_out_valid), .out_ready(w_out_ready),
        .out_block(c_out_block));

    aes_iter_core #(.KEY_SIZE(256), .RPC(2)) u_d (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(d_in_ready),
        .in_block(w_in_block), .in_key(w_key256),
        .out_valid(d_out_valid), .out_ready(w_out_ready),
        .out_block(d_out_block));

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [127:0] blk, input logic [127:0] key,
                          input logic [127:0] ct);
        a_in_valid = 1'b1;
        a_in_block = blk;
        a_in_key   = key;
        exp_q.push_back(ct);
        step();
        a_in_valid = 1'b0;
        a_in_block = rnd128();
        a_in_key   = rnd128();
    endtask

    task automatic wait_a(input int budget, output int n);
        n = 0;
        while (!a_out_valid && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", a_out_valid);
        end
        checks++;
        if (a_out_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_out_block: got %h expected 0", a_out_block);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_kat_128();
        int n;
        logic [127:0] e;
        a_out_ready = 1'b1;
        send_a(PT, K128, CT128);
        wait_a(30, n);
        checks++;
        if (n !== 10 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL kat128_latency: got %0d expected 10", n);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_out_block !== e) begin
            errors++;
            $display("FAIL kat128_value: got %h expected %h", a_out_block, e);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kat128_handshake: valid %b ready %b expected 0 1",
                     a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_kat_wide();
        int lb, lc, ld;
        logic [127:0] vb, vc, vd;
        lb = -1; lc = -1; ld = -1;
        vb = '0; vc = '0; vd = '0;
        w_out_ready = 1'b0;
        w_in_valid  = 1'b1;
        w_in_block  = PT;
        w_key192    = K192;
        w_key256    = K256;
        step();
        w_in_valid = 1'b0;
        w_in_block = rnd128();
        w_key192   = {rnd128(), rnd128()};
        w_key256   = {rnd128(), rnd128()};
        for (int n = 1; n <= 20; n++) begin
            step();
            if (b_out_valid && lb < 0) begin lb = n; vb = b_out_block; end
            if (c_out_valid && lc < 0) begin lc = n; vc = c_out_block; end
            if (d_out_valid && ld < 0) begin ld = n; vd = d_out_block; end
        end
        checks++;
        if (lb !== 6) begin
            errors++;
            $display("FAIL k192r2_latency: got %0d expected 6", lb);
        end
        checks++;
        if (vb !== CT192) begin
            errors++;
            $display("FAIL k192r2_value: got %h expected %h", vb, CT192);
        end
        checks++;
        if (lc !== 14) begin
            errors++;
            $display("FAIL k256r1_latency: got %0d expected 14", lc);
        end
        checks++;
        if (vc !== CT256) begin
            errors++;
            $display("FAIL k256r1_value: got %h expected %h", vc, CT256);
        end
        checks++;
        if (ld !== 7) begin
            errors++;
            $display("FAIL k256r2_latency: got %0d expected 7", ld);
        end
        checks++;
        if (vd !== CT256) begin
            errors++;
            $display("FAIL k256r2_value: got %h expected %h", vd, CT256);
        end
        checks++;
        if (b_out_block !== CT192 || b_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL k192r2_hold: got %h expected %h",
                     b_out_block, CT192);
        end
        w_out_ready = 1'b1;
        step();
        w_out_ready = 1'b0;
        checks++;
        if ({b_in_ready, c_in_ready, d_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL wide_return_idle: got %b expected 111",
                     {b_in_ready, c_in_ready, d_in_ready});
        end
    endtask

    task automatic test_backpressure();
        int n;
        int busy_bad;
        int hold_bad;
        logic [127:0] e, held;
        busy_bad = 0;
        hold_bad = 0;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_block  = 128'h3243f6a8885a308d313198a2e0370734;
        a_in_key    = KB;
        exp_q.push_back(128'h3925841d02dc09fbdc118597196a0b32);
        step();
        n = 0;
        while (!a_out_valid && n < 30) begin
            if (a_in_ready !== 1'b0) busy_bad++;
            a_in_block = rnd128();
            a_in_key   = rnd128();
            step();
            n++;
        end
        checks++;
        if (n !== 10 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 10", n);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL bp_no_accept_in_run: got %0d ready cycles expected 0",
                     busy_bad);
        end
        e = exp_q.pop_front();
        held = a_out_block;
        checks++;
        if (held !== e) begin
            errors++;
            $display("FAIL bp_value: got %h expected %h", held, e);
        end
        for (int i = 0; i < 20; i++) begin
            a_in_block = rnd128();
            step();
            if (a_out_block !== held || a_in_ready !== 1'b0 ||
                a_out_valid !== 1'b1) hold_bad++;
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", hold_bad);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b expected 0 1",
                     a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        logic [127:0] e;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_block  = PT;
        a_in_key    = K128;
        step();
        a_in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flags: valid %b ready %b expected 0 1",
                     a_out_valid, a_in_ready);
        end
        checks++;
        if (a_out_block !== 128'h0) begin
            errors++;
            $display("FAIL rst_mid_state: got %h expected 0", a_out_block);
        end
        step();
        rst = 1'b1;
        step();
        send_a(PT, K128, CT128);
        wait_a(30, n);
        checks++;
        if (n !== 10 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_latency: got %0d expected 10", n);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_out_block !== e) begin
            errors++;
            $display("FAIL rst_mid_value: got %h expected %h", a_out_block, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [4];
        logic [127:0] keys [4];
        logic [127:0] cts [4];
        int vt [4];
        int idx, got, cyc, zero_bad;
        logic [127:0] e;
        pts[0] = PT;  keys[0] = K128; cts[0] = CT128;
        pts[1] = 128'h3243f6a8885a308d313198a2e0370734; keys[1] = KB;
        cts[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        pts[2] = 128'h6bc1bee22e409f96e93d7e117393172a; keys[2] = KB;
        cts[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pts[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; keys[3] = KB;
        cts[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        idx = 0; got = 0; cyc = 0; zero_bad = 0;
        a_out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (a_out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++;
                if (a_out_block !== e) begin
                    errors++;
                    $display("FAIL b2b_value%0d: got %h expected %h",
                             got, a_out_block, e);
                end
                vt[got] = cyc;
                got++;
            end else if (a_out_block !== 128'h0) begin
                zero_bad++;
            end
            if (a_in_ready && idx < 4) begin
                a_in_valid = 1'b1;
                a_in_block = pts[idx];
                a_in_key   = keys[idx];
                exp_q.push_back(cts[idx]);
                idx++;
            end else begin
                a_in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        a_in_valid = 1'b0;
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", got);
        end
        // 10 RUN cycles, one DONE cycle, one IDLE cycle to accept the next
        for (int i = 1; i < got; i++) begin
            checks++;
            if (vt[i] - vt[i-1] !== 12) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d expected 12",
                         i, vt[i] - vt[i-1]);
            end
        end
`ifdef AES_ZEROIZE_EN
        checks++;
        if (zero_bad !== 0) begin
            errors++;
            $display("FAIL b2b_zeroize: got %0d nonzero cycles expected 0",
                     zero_bad);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_block = '0; a_in_key = '0;
        a_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_block = '0; w_out_ready = 1'b0;
        w_key192 = '0; w_key256 = '0;
        test_reset();
        test_kat_128();
        test_kat_wide();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
